// File: rtl/i_mem_pkg.sv
// i_mem_pkg: shared word type and constants for the instruction memory.
package i_mem_pkg;
    localparam int WORD_W     = 32;
    localparam int BYTE_OFF_W = 2;
    typedef logic [WORD_W-1:0] word_t;
    localparam word_t RESET_WORD = 32'h0000_0000;
endpackage

// File: rtl/i_mem_array.sv
// i_mem_array: DEPTH x 32 register file, async active-low clear, sync write, comb read.
// Ports: clk, rst (async active-low clear of every word), wr_en_i/wr_idx_i/wr_data_i
// (write port, sampled on rising clk), rd_idx_i -> rd_data_o (combinational read).
module i_mem_array
    import i_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [31:0]      wr_data_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [31:0]      rd_data_o
);
    word_t mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= RESET_WORD;
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];
endmodule

// File: rtl/i_mem.sv
// i_mem: instruction memory, word-indexed by a byte address, combinational fetch.
// Ports: clk, rst (async active-low, clears array), i_mem_address (byte address,
// bits [1:0] and bits above the index are ignored), i_mem_wr_en / i_mem_wr_data
// (synchronous word write), inst (word at current address).
// Option: define I_MEM_WR_BYPASS_EN to forward write data to inst in the same cycle.
module i_mem
    import i_mem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_mem_address,
    input  logic              i_mem_wr_en,
    input  logic [31:0]       i_mem_wr_data,
    output logic [31:0]       inst
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0] idx;
    word_t            rd_data;
    logic             unused_addr_bits;

    // Read and write share one address, so the write index always equals the read index.
    assign idx = i_mem_address[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
    assign unused_addr_bits = ^{i_mem_address[ADDR_W-1:IDX_W+BYTE_OFF_W], i_mem_address[BYTE_OFF_W-1:0]};

    i_mem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (i_mem_wr_en),
        .wr_idx_i  (idx),
        .wr_data_i (i_mem_wr_data),
        .rd_idx_i  (idx),
        .rd_data_o (rd_data)
    );

`ifdef I_MEM_WR_BYPASS_EN
    assign inst = (i_mem_wr_en && rst) ? i_mem_wr_data : rd_data;
`else
    assign inst = rd_data;
`endif
endmodule

// File: tb/tb_i_mem.sv
// tb_i_mem: directed self-checking bench for i_mem.
module tb_i_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [31:0] inst;
    int          checks = 0;
    int          failures = 0;

    i_mem #(.DEPTH(256), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_mem_address (addr),
        .i_mem_wr_en   (wr_en),
        .i_mem_wr_data (wr_data),
        .inst          (inst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wr_data = d; wr_en = 1'b1;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1 chk(tag, inst, exp);
    endtask

    initial begin
        #2 rst = 1'b0;
        rd("rst_a0", 32'h0, 32'h0);
        rd("rst_a4", 32'h4, 32'h0);
        rd("rst_a8", 32'h8, 32'h0);
        wr(32'h0, 32'hFFFF_FFFF);
        rd("rst_wr_ignored", 32'h0, 32'h0);
        #12;
        @(negedge clk);
        rst = 1'b1;
        wr(32'h0, 32'h0000_00FF);
        wr(32'h4, 32'h0000_FFFF);
        wr(32'h8, 32'h00FF_FFFF);
        rd("rb_a0", 32'h0, 32'h0000_00FF);
        rd("rb_a4", 32'h4, 32'h0000_FFFF);
        rd("rb_a8", 32'h8, 32'h00FF_FFFF);
        rd("rb_a9_align", 32'h9, 32'h00FF_FFFF);
        wr(32'h0, 32'h1234_5678);
        rd("align_a3", 32'h3, 32'h1234_5678);
        rd("wrap_a400", 32'h400, 32'h1234_5678);
        rd("wrap_a408", 32'h408, 32'h00FF_FFFF);
        wr(32'h4, 32'hAAAA_5555);
        rd("pre_a4", 32'h4, 32'hAAAA_5555);
        @(negedge clk);
        addr = 32'h4; wr_data = 32'hDEAD_BEEF; wr_en = 1'b1;
        #1;
`ifdef I_MEM_WR_BYPASS_EN
        chk("same_cyc_before", inst, 32'hDEAD_BEEF);
`else
        chk("same_cyc_before", inst, 32'hAAAA_5555);
`endif
        @(posedge clk);
        #1 chk("same_cyc_after", inst, 32'hDEAD_BEEF);
        wr_en = 1'b0;
        @(negedge clk);
        addr = 32'h8; wr_data = 32'hFFFF_FFFF; wr_en = 1'b0;
        @(posedge clk);
        #1 chk("wr_dis_a8", inst, 32'h00FF_FFFF);
        rd("wr_dis_a4", 32'h4, 32'hDEAD_BEEF);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("mid_rst_a4", inst, 32'h0);
        addr = 32'h8; wr_data = 32'h5555_AAAA; wr_en = 1'b1;
        @(posedge clk);
        #1 chk("mid_rst_wr_ignored", inst, 32'h0);
        wr_en = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        rd("post_rst_a8", 32'h8, 32'h0);
        rd("post_rst_a0", 32'h0, 32'h0);
        rd("post_rst_a4", 32'h4, 32'h0);
        wr(32'hC, 32'hCAFE_F00D);
        rd("post_rst_wr_ac", 32'hC, 32'hCAFE_F00D);
        rd("post_rst_wr_a40c", 32'h40C, 32'hCAFE_F00D);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
